// File: rtl/input_conditioner.sv
// Button front end: sync + debounce nine raw buttons, detect presses, auto-repeat directions, one action pulse per cycle.
// Latency: uncontended press pulses DEBOUNCE_CYCLES+4 edges after the raw level is first sampled high; +1 per higher-priority contender.
// Backpressure: none downstream; simultaneous events queue as pending bits and drain one per cycle, repeats of a queued bit coalesce.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ENABLE_REPEAT   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_rotate,
  input  logic btn_place,
  input  logic btn_sel1,
  input  logic btn_sel2,
  input  logic btn_sel3,
  output logic move_left,
  output logic move_right,
  output logic move_up,
  output logic move_down,
  output logic rotate_block,
  output logic place_block,
  output logic sel1,
  output logic sel2,
  output logic sel3,
  output logic pending_any
);

  // Bit index doubles as priority: bit 0 (place) wins, bit 8 (down) loses.
  localparam int NB     = 9;
  localparam int B_LEFT = 5;  // directions occupy bits 5..8
  localparam int DBW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW     = $clog2(RMAX + 1);
  localparam logic [HW-1:0] DLY_V = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] PER_V = HW'(REPEAT_PERIOD);

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] w_deb;
  logic [NB-1:0] r_deb_d;
  logic [NB-1:0] w_press;
  logic [3:0]    w_rep;
  logic [NB-1:0] w_evt;
  logic [NB-1:0] w_grant;
  logic [NB-1:0] w_pend_nxt;
  logic [NB-1:0] r_pend;
  logic [NB-1:0] r_out;
  logic          r_pend_any;

  assign w_raw = {btn_down, btn_up, btn_right, btn_left,
                  btn_sel3, btn_sel2, btn_sel1, btn_rotate, btn_place};

  // Two-flop synchroniser for every raw button level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [DBW-1:0] r_cnt;
    logic           r_state;

    // Flip the debounced state only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt   <= '0;
        r_state <= 1'b0;
      end else if (r_sync2[i] == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt   <= '0;
        r_state <= r_sync2[i];
      end else begin
        r_cnt <= r_cnt + DBW'(1);
      end
    end

    assign w_deb[i] = r_state;
  end

  // Previous debounced state, used to find the 0->1 press edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_deb_d <= '0;
    else        r_deb_d <= w_deb;
  end

  assign w_press = w_deb & ~r_deb_d;

  for (genvar d = 0; d < 4; d++) begin : g_rep
    if (ENABLE_REPEAT) begin : g_on
      logic [HW-1:0] r_hold;
      logic          r_rpt;   // past the initial delay, now pacing by period
      logic [HW-1:0] w_tgt;

      assign w_tgt    = r_rpt ? PER_V : DLY_V;
      assign w_rep[d] = w_deb[B_LEFT+d] & ~w_press[B_LEFT+d] & (r_hold == w_tgt);

      // Hold counter restarts at 1 after each repeat so the next one lands a full period later.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_hold <= '0;
          r_rpt  <= 1'b0;
        end else if (!w_deb[B_LEFT+d] || w_press[B_LEFT+d]) begin
          r_hold <= '0;
          r_rpt  <= 1'b0;
        end else if (w_rep[d]) begin
          r_hold <= HW'(1);
          r_rpt  <= 1'b1;
        end else begin
          r_hold <= r_hold + HW'(1);
        end
      end
    end else begin : g_off
      assign w_rep[d] = 1'b0;
    end
  end

  assign w_evt = w_press | {w_rep, 5'b0_0000};

  // Lowest set bit is the highest-priority pending event.
  assign w_grant    = r_pend & (~r_pend + NB'(1));
  // A same-cycle event on the granted bit re-sets it, so it is issued again later.
  assign w_pend_nxt = (r_pend & ~w_grant) | w_evt;

  // Pending queue, registered action pulses and registered pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_out      <= '0;
      r_pend_any <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_out      <= w_grant;
      r_pend_any <= |w_pend_nxt;
    end
  end

  assign place_block  = r_out[0];
  assign rotate_block = r_out[1];
  assign sel1         = r_out[2];
  assign sel2         = r_out[3];
  assign sel3         = r_out[4];
  assign move_left    = r_out[5];
  assign move_right   = r_out[6];
  assign move_up      = r_out[7];
  assign move_down    = r_out[8];
  assign pending_any  = r_pend_any;

endmodule
